program_entry_memory: RTL and testbench

- Next-generation switch-driven program loader.
- Assembles instructions field by field from board switches (opcode, reg1, reg2, immediate) into a parametrised program memory.
- Then streams the stored program to the execution unit over a valid/ready fetch interface.
- Replaces the separate hand-indexed entry/memory pair with one FSM-controlled block, adding overflow detection, clear, and run-mode readout.

---
 rtl/program_entry_memory.sv | 174 +++++++++++++++++
 tb/tb_program_entry_memory.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_entry_memory.sv
// Switch-driven program loader: assembles instructions field by field
// into a small program memory, then streams it over a fetch handshake.
module program_entry_memory #(
  parameter  int OP_W    = 4,
  parameter  int REG_W   = 3,
  parameter  int IMM_W   = 8,
  parameter  int SW_W    = 8,
  parameter  int DEPTH   = 16,
  localparam int INSTR_W = OP_W + 2 * REG_W + IMM_W,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SW_W-1:0]    switches,
  input  logic               step,
  input  logic               clear,
  input  logic               run_start,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [AW-1:0]      fetch_addr,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               overflow,
  output logic [2:0]         entry_state,
  output logic               done
);

  localparam int F1 = (OP_W > REG_W) ? OP_W : REG_W;
  localparam int F2 = (F1 > IMM_W) ? F1 : IMM_W;
  localparam int XW = (F2 > SW_W) ? F2 : SW_W;

  typedef enum logic [2:0] {
    OP_E   = 3'd0,
    R1_E   = 3'd1,
    R2_E   = 3'd2,
    IMM_E  = 3'd3,
    COMMIT = 3'd4,
    RUN    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [REG_W-1:0]   r1_q, r1_d;
  logic [REG_W-1:0]   r2_q, r2_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [XW-1:0]      sw_x;
  logic [CW-1:0]      cnt_m1;
  logic               full_w;
  logic               last;
  logic               start_ok;

  // Fields narrower than the switch bus take its LSBs; wider ones zero-extend.
  assign sw_x     = XW'(switches);
  assign full_w   = (count_q == CW'(DEPTH));
  assign cnt_m1   = count_q - 1'b1;
  assign last     = ({1'b0, ptr_q} == cnt_m1);
  assign start_ok = run_start && (count_q != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OP_E;
      op_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      imm_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      imm_q   <= imm_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= {op_q, r1_q, r2_q, imm_q};
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = OP_E;
    end else begin
      unique case (state_q)
        OP_E: begin
          if (start_ok)  state_d = RUN;
          else if (step) state_d = R1_E;
        end
        R1_E:    if (step) state_d = R2_E;
        R2_E:    if (step) state_d = IMM_E;
        IMM_E:   if (step) state_d = COMMIT;
        COMMIT:  state_d = OP_E;
        RUN:     if (fetch_ready && last) state_d = OP_E;
        default: state_d = OP_E;
      endcase
    end
  end

  always_comb begin
    op_d    = op_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    imm_d   = imm_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    if (clear) begin
      op_d    = '0;
      r1_d    = '0;
      r2_d    = '0;
      imm_d   = '0;
      count_d = '0;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        OP_E: begin
          if (start_ok)  ptr_d = '0;
          else if (step) op_d = sw_x[OP_W-1:0];
        end
        R1_E:  if (step) r1_d = sw_x[REG_W-1:0];
        R2_E:  if (step) r2_d = sw_x[REG_W-1:0];
        IMM_E: if (step) imm_d = sw_x[IMM_W-1:0];
        COMMIT: begin
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        RUN: begin
          if (fetch_ready) begin
            if (last) done_d = 1'b1;
            else      ptr_d  = ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory is only visible while a word is actually being presented.
  always_comb begin
    fetch_valid = (state_q == RUN);
    fetch_instr = fetch_valid ? mem_q[ptr_q] : '0;
    fetch_addr  = fetch_valid ? ptr_q : '0;
    count       = count_q;
    full        = full_w;
    overflow    = ovf_q;
    entry_state = state_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_program_entry_memory.sv
// Scoreboard bench for program_entry_memory: entry, replay, stall,
// overflow, clear, ignored controls and mid-run reset.
module tb_program_entry_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  switches;
  logic        step, clear, run_start, fetch_ready;
  logic        fetch_valid;
  logic [17:0] fetch_instr;
  logic [3:0]  fetch_addr;
  logic [4:0]  count;
  logic        full, overflow, done;
  logic [2:0]  entry_state;

  int total = 0;
  int passed = 0;
  logic [17:0] prog [$];
  logic [17:0] sb [$];

  program_entry_memory dut (
    .clock(clock), .reset(reset), .switches(switches),
    .step(step), .clear(clear), .run_start(run_start),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_addr(fetch_addr),
    .count(count), .full(full), .overflow(overflow),
    .entry_state(entry_state), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] mkword(
    input logic [7:0] o, input logic [7:0] a,
    input logic [7:0] b, input logic [7:0] im);
    return {o[3:0], a[2:0], b[2:0], im};
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_step(input logic [7:0] v);
    switches = v; step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic enter(input logic [7:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] im);
    do_step(o); do_step(a); do_step(b); do_step(im); tick();
    if (prog.size() < 16) prog.push_back(mkword(o, a, b, im));
  endtask

  task automatic reset_dut();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    prog.delete();
  endtask

  task automatic run_prog(input int stall);
    logic [17:0] exp;
    int idx;
    sb = prog; idx = 0;
    fetch_ready = 1'b0; run_start = 1'b1; tick(); run_start = 1'b0;
    for (int c = 0; c < stall; c++) begin
      total++;
      if (fetch_valid !== 1'b1 || fetch_instr !== sb[0] || fetch_addr !== 4'd0)
        $display("FAIL stall_hold: got v=%b i=%h a=%0d want v=1 i=%h a=0",
                 fetch_valid, fetch_instr, fetch_addr, sb[0]);
      else passed++;
      tick();
    end
    fetch_ready = 1'b1;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      total++;
      if (fetch_valid !== 1'b1 || fetch_instr !== exp || fetch_addr !== 4'(idx))
        $display("FAIL xfer%0d: got v=%b i=%h a=%0d want v=1 i=%h a=%0d",
                 idx, fetch_valid, fetch_instr, fetch_addr, exp, idx);
      else passed++;
      idx++;
      tick();
      if (sb.size() > 0) begin
        total++;
        if (done !== 1'b0) $display("FAIL early_done: got %b want 0", done);
        else passed++;
      end
    end
    fetch_ready = 1'b0;
    total++;
    if (done !== 1'b1 || fetch_valid !== 1'b0 || entry_state !== 3'd0)
      $display("FAIL run_end: got d=%b v=%b s=%0d want d=1 v=0 s=0",
               done, fetch_valid, entry_state);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done);
    else passed++;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (fetch_valid !== 0 || fetch_instr !== 0 || fetch_addr !== 0 ||
        count !== 0 || full !== 0 || overflow !== 0 ||
        entry_state !== 0 || done !== 0)
      $display("FAIL reset: got v=%b i=%h a=%0d c=%0d f=%b o=%b s=%0d d=%b want all 0",
               fetch_valid, fetch_instr, fetch_addr, count, full,
               overflow, entry_state, done);
    else passed++;
  endtask

  task automatic test_single();
    logic [2:0] exp_st [5];
    logic [7:0] vals [4];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    vals = '{8'd1, 8'd0, 8'd0, 8'd192};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) do_step(vals[i]);
      else tick();
      total++;
      if (entry_state !== exp_st[i])
        $display("FAIL entry_st%0d: got %0d want %0d", i, entry_state, exp_st[i]);
      else passed++;
    end
    prog.push_back(mkword(8'd1, 8'd0, 8'd0, 8'd192));
    total++;
    if (count !== 5'd1) $display("FAIL single_count: got %0d want 1", count);
    else passed++;
    run_start = 1'b1; tick(); run_start = 1'b0;
    total++;
    if (fetch_valid !== 1'b1 || fetch_instr !== 18'h040C0 || fetch_addr !== 4'd0)
      $display("FAIL single_word: got v=%b i=%h a=%0d want v=1 i=040c0 a=0",
               fetch_valid, fetch_instr, fetch_addr);
    else passed++;
    fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
    total++;
    if (done !== 1'b1 || fetch_valid !== 1'b0)
      $display("FAIL single_done: got d=%b v=%b want d=1 v=0", done, fetch_valid);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL single_done_low: got %b want 0", done);
    else passed++;
  endtask

  task automatic test_stall();
    reset_dut();
    enter(8'hF3, 8'hFD, 8'h0A, 8'h5A);
    enter(8'h07, 8'h02, 8'hF6, 8'hA5);
    enter(8'h1C, 8'h47, 8'h01, 8'h00);
    run_prog(4);
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 16; i++)
      enter(8'(i), 8'(i + 1), 8'(i + 2), 8'(i * 7 + 3));
    total++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0)
      $display("FAIL fill: got c=%0d f=%b o=%b want c=16 f=1 o=0",
               count, full, overflow);
    else passed++;
    enter(8'h0F, 8'h07, 8'h07, 8'hFF);
    total++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1)
      $display("FAIL overflow: got c=%0d f=%b o=%b want c=16 f=1 o=1",
               count, full, overflow);
    else passed++;
    run_prog(0);
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
    else passed++;
  endtask

  task automatic test_clear();
    reset_dut();
    for (int i = 0; i < 5; i++) enter(8'(i + 2), 8'd1, 8'd2, 8'(i));
    do_step(8'h3); do_step(8'h4);
    total++;
    if (entry_state !== 3'd2 || count !== 5'd5)
      $display("FAIL pre_clear: got s=%0d c=%0d want s=2 c=5", entry_state, count);
    else passed++;
    clear = 1'b1; tick(); clear = 1'b0;
    prog.delete();
    total++;
    if (count !== 0 || entry_state !== 0 || overflow !== 0 || done !== 0)
      $display("FAIL clear: got c=%0d s=%0d o=%b d=%b want 0 0 0 0",
               count, entry_state, overflow, done);
    else passed++;
    run_start = 1'b1; tick(); run_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (fetch_valid !== 1'b0 || entry_state !== 3'd0)
        $display("FAIL clr_run%0d: got v=%b s=%0d want v=0 s=0",
                 i, fetch_valid, entry_state);
      else passed++;
      tick();
    end
  endtask

  task automatic test_ignored();
    reset_dut();
    run_start = 1'b1; tick(); run_start = 1'b0;
    total++;
    if (fetch_valid !== 1'b0 || entry_state !== 3'd0)
      $display("FAIL run_empty: got v=%b s=%0d want v=0 s=0", fetch_valid, entry_state);
    else passed++;
    enter(8'h2, 8'h3, 8'h4, 8'h5);
    do_step(8'h1);
    run_start = 1'b1; tick(); run_start = 1'b0;
    total++;
    if (fetch_valid !== 1'b0 || entry_state !== 3'd1)
      $display("FAIL run_mid: got v=%b s=%0d want v=0 s=1", fetch_valid, entry_state);
    else passed++;
    do_step(8'h6); do_step(8'h7); do_step(8'h8);
    switches = 8'h9; step = 1'b1; tick(); step = 1'b0;
    prog.push_back(mkword(8'h1, 8'h6, 8'h7, 8'h8));
    total++;
    if (entry_state !== 3'd0 || count !== 5'd2)
      $display("FAIL step_commit: got s=%0d c=%0d want s=0 c=2", entry_state, count);
    else passed++;
    run_start = 1'b1; tick(); run_start = 1'b0;
    do_step(8'hEE);
    run_start = 1'b1; tick(); run_start = 1'b0;
    total++;
    if (entry_state !== 3'd5 || count !== 5'd2 || fetch_addr !== 4'd0)
      $display("FAIL step_run: got s=%0d c=%0d a=%0d want s=5 c=2 a=0",
               entry_state, count, fetch_addr);
    else passed++;
    fetch_ready = 1'b1; tick(); tick(); fetch_ready = 1'b0;
    total++;
    if (done !== 1'b1 || entry_state !== 3'd0)
      $display("FAIL ign_done: got d=%b s=%0d want d=1 s=0", done, entry_state);
    else passed++;
    tick();
    run_prog(0);
  endtask

  task automatic test_reset_mid_run();
    reset_dut();
    for (int i = 0; i < 4; i++) enter(8'(i + 9), 8'(i), 8'(i + 3), 8'(i * 17));
    run_start = 1'b1; tick(); run_start = 1'b0;
    fetch_ready = 1'b1; tick(); tick(); fetch_ready = 1'b0;
    total++;
    if (fetch_valid !== 1'b1 || fetch_addr !== 4'd2 || fetch_instr !== prog[2])
      $display("FAIL mid_ptr: got v=%b a=%0d i=%h want v=1 a=2 i=%h",
               fetch_valid, fetch_addr, fetch_instr, prog[2]);
    else passed++;
    reset = 1'b1; fetch_ready = 1'b1; tick(); reset = 1'b0; fetch_ready = 1'b0;
    prog.delete();
    total++;
    if (fetch_valid !== 0 || count !== 0 || entry_state !== 0 || done !== 0)
      $display("FAIL mid_reset: got v=%b c=%0d s=%0d d=%b want 0 0 0 0",
               fetch_valid, count, entry_state, done);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; switches = '0; step = 1'b0; clear = 1'b0;
    run_start = 1'b0; fetch_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_clear();
    test_ignored();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
